// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths, constants and the stored fetch entry type.
package fetch_queue_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push and decode-side pop handshakes of the fetch queue.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    import fetch_queue_pkg::*;
    logic                     in_valid;
    logic [ADDR_W-1:0]        in_pc;
    logic [INSTR_W-1:0]       in_instr;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_pc;
    logic [ADDR_W-1:0]        out_pc_plus4;
    logic [INSTR_W-1:0]       out_instr;
    logic                     out_misaligned;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_pc_plus4, out_instr, out_misaligned, count
    );
    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_pc_plus4, out_instr, out_misaligned, count
    );
endinterface

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: DEPTH-entry register array, synchronous write, combinational read.
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);
    entry_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fall-through FIFO of {PC, instruction} between fetch and decode.
// Ready doubles as the PC write-enable; flush drops everything on a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_flush,
    fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_in_ready, w_out_valid, w_push, w_pop;
    entry_t        w_rdata;

    assign w_in_ready  = !i_rst && (r_count < CW'(DEPTH));
    assign w_out_valid = !i_rst && (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready && !i_flush;
    assign w_pop       = w_out_valid && bus.out_ready && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    fetch_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata ('{pc: bus.in_pc, instr: bus.in_instr}),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // Empty queue presents PC 0 and a NOP so decode never sees stale storage.
    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_pc         = w_out_valid ? w_rdata.pc : '0;
    assign bus.out_pc_plus4   = w_out_valid ? w_rdata.pc + PC_INCR : '0;
    assign bus.out_instr      = w_out_valid ? w_rdata.instr : NOP_INSTR;
    assign bus.out_misaligned = w_out_valid && (w_rdata.pc[1:0] != 2'b00);
    assign bus.count          = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of the fetch queue handshakes, flush, reset and PC+4.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int checks = 0;
    int failures = 0;

    fetch_queue_if #(.DEPTH(4)) bus ();

    fetch_queue #(.DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_pc = '0;
        bus.in_instr = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pc = 32'h0040_0000 + 32'(4 * i);
            bus.in_instr = 32'h2000_0000 + 32'(i);
            step();
        end
        chk("full_count", 32'(bus.count), 4);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        bus.in_pc = 32'h0040_0010;
        step();
        bus.in_valid = 1'b0;
        chk("fifth_count", 32'(bus.count), 4);
        chk("full_out_pc", bus.out_pc, 32'h0040_0000);
        chk("full_out_pc4", bus.out_pc_plus4, 32'h0040_0004);
        chk("full_out_instr", bus.out_instr, 32'h2000_0000);
        chk("full_misaligned", 32'(bus.out_misaligned), 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", bus.out_pc, 32'h0040_0000 + 32'(4 * i));
            chk("drain_instr", bus.out_instr, 32'h2000_0000 + 32'(i));
            step();
        end
        chk("drained_count", 32'(bus.count), 0);
        chk("drained_valid", 32'(bus.out_valid), 0);
        chk("drained_pc", bus.out_pc, 0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h0040_1000;
        bus.in_instr = 32'h3000_0000;
        step();
        chk("prime_count", 32'(bus.count), 1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("stream_pc", bus.out_pc, 32'h0040_1000 + 32'(4 * k));
            chk("stream_instr", bus.out_instr, 32'h3000_0000 + 32'(k));
            bus.in_pc = 32'h0040_1004 + 32'(4 * k);
            bus.in_instr = 32'h3000_0001 + 32'(k);
            step();
            chk("stream_count", 32'(bus.count), 1);
        end
        chk("stream_tail_pc", bus.out_pc, 32'h0040_1028);
        bus.out_ready = 1'b0;
        bus.in_pc = 32'h0040_2000;
        step();
        bus.in_pc = 32'h0040_2004;
        step();
        chk("pre_flush_count", 32'(bus.count), 3);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_pc = 32'h0040_0100;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_in_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h0040_0200;
        bus.in_instr = 32'h0000_ABCD;
        step();
        bus.in_valid = 1'b0;
        chk("post_flush_count", 32'(bus.count), 1);
        chk("post_flush_pc", bus.out_pc, 32'h0040_0200);
        chk("post_flush_instr", bus.out_instr, 32'h0000_ABCD);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("post_flush_pop", 32'(bus.count), 0);
        bus.in_valid = 1'b1;
        bus.in_pc = 32'hFFFF_FFFC;
        bus.in_instr = 32'h1111_1111;
        step();
        bus.in_pc = 32'h0040_0002;
        bus.in_instr = 32'h2222_2222;
        step();
        bus.in_valid = 1'b0;
        chk("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", bus.out_pc_plus4, 32'h0000_0000);
        chk("wrap_misaligned", 32'(bus.out_misaligned), 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("mis_pc", bus.out_pc, 32'h0040_0002);
        chk("mis_pc4", bus.out_pc_plus4, 32'h0040_0006);
        chk("mis_flag", 32'(bus.out_misaligned), 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("mis_pop_count", 32'(bus.count), 0);
        chk("empty_misaligned", 32'(bus.out_misaligned), 0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_pc = 32'h0040_0300 + 32'(4 * i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("refill_count", 32'(bus.count), 4);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_comb_valid", 32'(bus.out_valid), 0);
        chk("rst_comb_in_ready", 32'(bus.in_ready), 0);
        chk("rst_comb_pc", bus.out_pc, 0);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("midrst_count", 32'(bus.count), 0);
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_pc", bus.out_pc, 0);
        chk("midrst_pc4", bus.out_pc_plus4, 0);
        chk("midrst_instr", bus.out_instr, 0);
        chk("midrst_misaligned", 32'(bus.out_misaligned), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
